perm_out_pingpong_85b: RTL and testbench

PERM_OUT_PINGPONG_85B -- requirements
Module: perm_out_pingpong_85b

---
 rtl/perm_out_pingpong_85b.sv | 111 +++++++++++
 tb/tb_perm_out_pingpong_85b.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perm_out_pingpong_85b.sv
// Packs permutation-network bit-planes into per-column messages and buffers them
// in a 2-entry ping-pong store ahead of the message memory write port.

module perm_out_pack_col (
   input  logic       b0,
   input  logic       b1,
   input  logic       b2,
   input  logic       b3,
   output logic [3:0] nib
);
   assign nib = {b3, b2, b1, b0};
endmodule

module perm_out_pingpong_85b #(
   parameter int CHECK_PARALLELISM = 85,
   parameter int QUAN_SIZE         = 4,
   parameter int PAGE_NUM          = 8
) (
   input  logic                                   sys_clk,
   input  logic                                   rstn,
   input  logic [CHECK_PARALLELISM-1:0]           sw_in_bit0,
   input  logic [CHECK_PARALLELISM-1:0]           sw_in_bit1,
   input  logic [CHECK_PARALLELISM-1:0]           sw_in_bit2,
   input  logic [CHECK_PARALLELISM-1:0]           sw_in_bit3,
   input  logic                                   sw_valid,
   output logic [CHECK_PARALLELISM*QUAN_SIZE-1:0] msg_out,
   output logic                                   msg_valid,
   input  logic                                   msg_ready,
   output logic [$clog2(PAGE_NUM)-1:0]            page_addr,
   output logic                                   layer_done,
   output logic                                   ovf_err,
   input  logic                                   err_clr
);
   localparam int W  = CHECK_PARALLELISM * QUAN_SIZE;
   localparam int PW = $clog2(PAGE_NUM);
   localparam logic [PW-1:0] PAGE_LAST = PW'(PAGE_NUM - 1);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   logic [W-1:0]       word;
   logic [1:0][W-1:0]  entry;
   logic [1:0]         state, state_nxt;
   logic               wp, rp;
   logic               xfer, wr, ovf;

   // One packing cell per column; bit-plane k lands in nibble bit k.
   for (genvar i = 0; i < CHECK_PARALLELISM; i++) begin : g_col
      perm_out_pack_col u_col (
         .b0  (sw_in_bit0[i]),
         .b1  (sw_in_bit1[i]),
         .b2  (sw_in_bit2[i]),
         .b3  (sw_in_bit3[i]),
         .nib (word[QUAN_SIZE*i +: 4])
      );
   end

   assign msg_valid = (state != EMPTY);
   assign msg_out   = entry[rp];
   assign xfer      = msg_valid & msg_ready;
   // A transfer in the same cycle frees the slot, so FULL can still accept.
   assign wr        = sw_valid & ((state != FULL) | xfer);
   assign ovf       = sw_valid & (state == FULL) & ~xfer;

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (wr) state_nxt = ONE;
         ONE: begin
            if (wr && !xfer)      state_nxt = FULL;
            else if (xfer && !wr) state_nxt = EMPTY;
         end
         FULL:    if (xfer && !wr) state_nxt = ONE;
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         state <= EMPTY;
         wp    <= 1'b0;
         rp    <= 1'b0;
         entry <= '0;
      end else begin
         state <= state_nxt;
         if (wr) begin
            entry[wp] <= word;
            wp        <= ~wp;
         end
         if (xfer) rp <= ~rp;
      end
   end

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         page_addr  <= '0;
         layer_done <= 1'b0;
      end else begin
         layer_done <= xfer && (page_addr == PAGE_LAST);
         if (xfer) page_addr <= (page_addr == PAGE_LAST) ? '0 : page_addr + 1'b1;
      end
   end

   // New overflow wins over a coincident clear.
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn)        ovf_err <= 1'b0;
      else if (ovf)     ovf_err <= 1'b1;
      else if (err_clr) ovf_err <= 1'b0;
   end
endmodule

// File: tb/tb_perm_out_pingpong_85b.sv
// Scoreboard bench: words expected at the output are queued when driven and
// popped by a monitor on each observed transfer.

module tb_perm_out_pingpong_85b;
   localparam int CP = 85;
   localparam int QS = 4;
   localparam int PN = 8;
   localparam int W  = CP * QS;
   localparam int PW = $clog2(PN);

   logic          sys_clk = 1'b0;
   logic          rstn;
   logic [CP-1:0] sw_in_bit0, sw_in_bit1, sw_in_bit2, sw_in_bit3;
   logic          sw_valid;
   logic [W-1:0]  msg_out;
   logic          msg_valid;
   logic          msg_ready;
   logic [PW-1:0] page_addr;
   logic          layer_done;
   logic          ovf_err;
   logic          err_clr;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0]  exp_q[$];
   logic [PW-1:0] exp_page = '0;
   logic          ld_exp   = 1'b0;

   perm_out_pingpong_85b #(.CHECK_PARALLELISM(CP), .QUAN_SIZE(QS), .PAGE_NUM(PN)) dut (
      .sys_clk    (sys_clk),
      .rstn       (rstn),
      .sw_in_bit0 (sw_in_bit0),
      .sw_in_bit1 (sw_in_bit1),
      .sw_in_bit2 (sw_in_bit2),
      .sw_in_bit3 (sw_in_bit3),
      .sw_valid   (sw_valid),
      .msg_out    (msg_out),
      .msg_valid  (msg_valid),
      .msg_ready  (msg_ready),
      .page_addr  (page_addr),
      .layer_done (layer_done),
      .ovf_err    (ovf_err),
      .err_clr    (err_clr)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic logic [W-1:0] pack(input logic [CP-1:0] p0, p1, p2, p3);
      logic [W-1:0] w;
      for (int i = 0; i < CP; i++) w[QS*i +: 4] = {p3[i], p2[i], p1[i], p0[i]};
      return w;
   endfunction

   function automatic logic [CP-1:0] rnd_plane();
      logic [CP-1:0] r;
      for (int i = 0; i < CP; i++) r[i] = 1'($urandom_range(0, 1));
      return r;
   endfunction

   task automatic put(input logic [CP-1:0] p0, p1, p2, p3, input bit keep);
      sw_in_bit0 = p0; sw_in_bit1 = p1; sw_in_bit2 = p2; sw_in_bit3 = p3;
      sw_valid = 1'b1;
      if (keep) exp_q.push_back(pack(p0, p1, p2, p3));
      @(posedge sys_clk); #1;
      sw_valid = 1'b0;
   endtask

   task automatic put_rand(input bit keep, output logic [W-1:0] w);
      logic [CP-1:0] a, b, c, d;
      a = rnd_plane(); b = rnd_plane(); c = rnd_plane(); d = rnd_plane();
      w = pack(a, b, c, d);
      put(a, b, c, d, keep);
   endtask

   task automatic tick();
      @(posedge sys_clk); #1;
   endtask

   // Monitor: checks every transfer against the scoreboard and the page model.
   initial begin
      logic [W-1:0] w;
      forever begin
         @(negedge sys_clk);
         if (!rstn) begin
            exp_page = '0;
            ld_exp   = 1'b0;
         end else begin
            checks++;
            if (layer_done !== ld_exp) begin
               failures++;
               $display("FAIL layer_done: got %b want %b at %0t", layer_done, ld_exp, $time);
            end
            ld_exp = 1'b0;
            if (msg_valid === 1'b1 && msg_ready === 1'b1) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_word: got %h with empty scoreboard", msg_out);
               end else begin
                  w = exp_q.pop_front();
                  if (msg_out !== w) begin
                     failures++;
                     $display("FAIL msg_out: got %h want %h", msg_out, w);
                  end
               end
               checks++;
               if (page_addr !== exp_page) begin
                  failures++;
                  $display("FAIL page_addr: got %0d want %0d", page_addr, exp_page);
               end
               ld_exp   = (exp_page == PW'(PN - 1));
               exp_page = (exp_page == PW'(PN - 1)) ? '0 : exp_page + 1'b1;
            end
         end
      end
   end

   task automatic drain(input string name);
      int n = 0;
      msg_ready = 1'b1;
      while (msg_valid === 1'b1 && n < 20) begin tick(); n++; end
      msg_ready = 1'b0;
      checks++;
      if (msg_valid !== 1'b0 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_drain: valid=%b pending=%0d want valid=0 pending=0", name, msg_valid, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0; sw_valid = 1'b0; msg_ready = 1'b0; err_clr = 1'b0;
      sw_in_bit0 = '0; sw_in_bit1 = '0; sw_in_bit2 = '0; sw_in_bit3 = '0;
      tick(); tick();
      checks++;
      if ({msg_valid, page_addr, layer_done, ovf_err} !== '0 || msg_out !== '0) begin
         failures++;
         $display("FAIL reset_outputs: valid=%b page=%0d ld=%b ovf=%b out=%h want all 0",
                  msg_valid, page_addr, layer_done, ovf_err, msg_out);
      end
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [W-1:0] exp_nib;
      exp_nib = '0;
      for (int i = 0; i < CP; i++) exp_nib[QS*i] = 1'b1;
      msg_ready = 1'b1;
      put({CP{1'b1}}, '0, '0, '0, 1'b1);
      checks++;
      if (msg_valid !== 1'b1 || msg_out !== exp_nib || page_addr !== '0) begin
         failures++;
         $display("FAIL basic_first: valid=%b page=%0d out=%h want valid=1 page=0 out=%h",
                  msg_valid, page_addr, msg_out, exp_nib);
      end
      tick();
      checks++;
      if (msg_valid !== 1'b0 || page_addr !== PW'(1)) begin
         failures++;
         $display("FAIL basic_after: valid=%b page=%0d want valid=0 page=1", msg_valid, page_addr);
      end
      msg_ready = 1'b0;
   endtask

   task automatic test_overflow();
      logic [W-1:0] a, b, c;
      msg_ready = 1'b0;
      put_rand(1'b1, a);
      put_rand(1'b1, b);
      put_rand(1'b0, c);
      checks++;
      if (ovf_err !== 1'b1 || msg_valid !== 1'b1 || msg_out !== a) begin
         failures++;
         $display("FAIL ovf_set: ovf=%b valid=%b out=%h want ovf=1 valid=1 out=%h", ovf_err, msg_valid, msg_out, a);
      end
      tick(); tick();
      checks++;
      if (msg_out !== a || msg_valid !== 1'b1) begin
         failures++;
         $display("FAIL ovf_hold: out=%h valid=%b want out=%h valid=1", msg_out, msg_valid, a);
      end
   endtask

   task automatic test_err_clr();
      logic [W-1:0] d;
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      checks++;
      if (ovf_err !== 1'b0) begin
         failures++;
         $display("FAIL err_clr: got %b want 0", ovf_err);
      end
      err_clr = 1'b1;
      put_rand(1'b0, d);
      err_clr = 1'b0;
      checks++;
      if (ovf_err !== 1'b1) begin
         failures++;
         $display("FAIL clr_vs_ovf: got %b want 1", ovf_err);
      end
      tick();
      checks++;
      if (ovf_err !== 1'b1) begin
         failures++;
         $display("FAIL ovf_sticky: got %b want 1", ovf_err);
      end
      drain("ovf");
      err_clr = 1'b1; tick(); err_clr = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] e, f, g;
      msg_ready = 1'b0;
      put_rand(1'b1, e);
      put_rand(1'b1, f);
      msg_ready = 1'b1;
      put_rand(1'b1, g);
      msg_ready = 1'b0;
      checks++;
      if (ovf_err !== 1'b0 || msg_valid !== 1'b1 || msg_out !== f) begin
         failures++;
         $display("FAIL b2b_full: ovf=%b valid=%b out=%h want ovf=0 valid=1 out=%h", ovf_err, msg_valid, msg_out, f);
      end
      msg_ready = 1'b1;
      tick();
      checks++;
      if (msg_valid !== 1'b1 || msg_out !== g) begin
         failures++;
         $display("FAIL b2b_second: valid=%b out=%h want valid=1 out=%h", msg_valid, msg_out, g);
      end
      tick();
      checks++;
      if (msg_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_empty: valid=%b want 0", msg_valid);
      end
      msg_ready = 1'b0;
   endtask

   task automatic test_pages();
      logic [W-1:0] w;
      int pulses = 0;
      int first  = -1;
      rstn = 1'b0; tick(); rstn = 1'b1; tick();
      msg_ready = 1'b1;
      for (int i = 0; i < PN; i++) put_rand(1'b1, w);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (layer_done === 1'b1) begin
            pulses++;
            if (first < 0) first = i;
         end
      end
      msg_ready = 1'b0;
      checks++;
      if (pulses != 1 || first != 0) begin
         failures++;
         $display("FAIL layer_pulse: pulses=%0d first=%0d want pulses=1 first=0", pulses, first);
      end
      checks++;
      if (page_addr !== '0 || msg_valid !== 1'b0) begin
         failures++;
         $display("FAIL page_wrap: page=%0d valid=%b want page=0 valid=0", page_addr, msg_valid);
      end
   endtask

   task automatic test_reset_midflight();
      logic [W-1:0] w;
      msg_ready = 1'b0;
      put_rand(1'b0, w);
      put_rand(1'b0, w);
      #2;
      rstn = 1'b0;
      sw_in_bit0 = rnd_plane(); sw_valid = 1'b1;
      #1;
      checks++;
      if ({msg_valid, page_addr, layer_done, ovf_err} !== '0 || msg_out !== '0) begin
         failures++;
         $display("FAIL async_reset: valid=%b page=%0d ld=%b ovf=%b out=%h want all 0",
                  msg_valid, page_addr, layer_done, ovf_err, msg_out);
      end
      @(posedge sys_clk); #2;
      sw_valid = 1'b0;
      #1 rstn = 1'b1;
      tick();
      checks++;
      if (msg_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_ignores_valid: valid=%b want 0", msg_valid);
      end
      msg_ready = 1'b1;
      put_rand(1'b1, w);
      checks++;
      if (msg_valid !== 1'b1 || msg_out !== w || page_addr !== '0) begin
         failures++;
         $display("FAIL post_reset_word: valid=%b page=%0d out=%h want valid=1 page=0 out=%h",
                  msg_valid, page_addr, msg_out, w);
      end
      drain("post_reset");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_err_clr();
      test_back_to_back();
      test_pages();
      test_reset_midflight();
      tick(); tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
